// File: rtl/spi_bus_slave.sv
// SPI mode-0 slave bridging host frames (command byte + data bytes) onto a parallel register bus.
// Define SPI_AUTOINC_EN to advance the bus address after every data byte within a frame.
module spi_bus_slave (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_sck,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_wr_n,
  output logic       o_rd_n,
  output logic [6:0] o_addr,
  output logic [7:0] o_data,
  input  logic [7:0] i_data
);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cs_sync_q, sck_sync_q, mosi_sync_q;
  logic        cs_prev_q, sck_prev_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic        is_read_q, is_read_d;
  logic [6:0]  frame_addr_q, frame_addr_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        miso_q, miso_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic        cs_s, cs_fall, cs_rise;
  logic        sck_rise, sck_fall;
  logic        mosi_s;
  logic [7:0]  rx_byte;

  function automatic logic [6:0] next_addr(input logic [6:0] a);
`ifdef SPI_AUTOINC_EN
    return a + 7'd1;
`else
    return a;
`endif
  endfunction

  assign cs_s     = cs_sync_q[1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[1] & sck_prev_q;
  assign mosi_s   = mosi_sync_q[1];
  assign rx_byte  = {rx_shift_q, mosi_s};

  // CS copies reset low so a frame already in progress at reset release is not seen as a new fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cs_sync_q   <= 2'b00;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], i_spi_cs_n};
      sck_sync_q  <= {sck_sync_q[0], i_spi_sck};
      mosi_sync_q <= {mosi_sync_q[0], i_spi_mosi};
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    is_read_d    = is_read_q;
    frame_addr_d = frame_addr_q;
    tx_shift_d   = tx_shift_q;
    miso_d       = miso_q;
    wr_n_d       = 1'b1;
    rd_n_d       = 1'b1;
    addr_d       = addr_q;
    data_d       = data_q;

    // Read data is sampled while the read strobe is on the bus.
    if (!rd_n_q) begin
      tx_shift_d = i_data;
    end

    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = StCmd;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 7'd0;
        end
      end
      StCmd: begin
        miso_d = 1'b0;
        if (sck_rise) begin
          bit_cnt_d  = bit_cnt_q + 3'd1;
          rx_shift_d = rx_byte[6:0];
          if (bit_cnt_q == 3'd7) begin
            state_d   = StData;
            is_read_d = rx_byte[7];
            if (rx_byte[7]) begin
              rd_n_d       = 1'b0;
              addr_d       = rx_byte[6:0];
              frame_addr_d = next_addr(rx_byte[6:0]);
            end else begin
              frame_addr_d = rx_byte[6:0];
            end
          end
        end
      end
      StData: begin
        if (sck_rise) begin
          bit_cnt_d  = bit_cnt_q + 3'd1;
          rx_shift_d = rx_byte[6:0];
          if (bit_cnt_q == 3'd7) begin
            addr_d       = frame_addr_q;
            frame_addr_d = next_addr(frame_addr_q);
            if (is_read_q) begin
              rd_n_d = 1'b0;
            end else begin
              wr_n_d = 1'b0;
              data_d = rx_byte;
            end
          end
        end
        if (sck_fall && is_read_q) begin
          miso_d     = tx_shift_q[7];
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
      default: state_d = StIdle;
    endcase

    // CS rise wins over any byte completing in the same cycle.
    if (cs_rise) begin
      state_d      = StIdle;
      wr_n_d       = 1'b1;
      rd_n_d       = 1'b1;
      miso_d       = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;
      frame_addr_d = frame_addr_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 7'd0;
      is_read_q    <= 1'b0;
      frame_addr_q <= 7'd0;
      tx_shift_q   <= 8'd0;
      miso_q       <= 1'b0;
      wr_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      addr_q       <= 7'd0;
      data_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      is_read_q    <= is_read_d;
      frame_addr_q <= frame_addr_d;
      tx_shift_q   <= tx_shift_d;
      miso_q       <= miso_d;
      wr_n_q       <= wr_n_d;
      rd_n_q       <= rd_n_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign o_spi_miso = miso_q;
  assign o_wr_n     = wr_n_q;
  assign o_rd_n     = rd_n_q;
  assign o_addr     = addr_q;
  assign o_data     = data_q;

endmodule

// File: tb/tb_spi_bus_slave.sv
// Directed bench for spi_bus_slave: SPI host model at i_clk/8 plus bus strobe monitor.
module tb_spi_bus_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       miso, wr_n, rd_n;
  logic [6:0] addr;
  logic [7:0] data;

  int total = 0;
  int bad = 0;

  always #10 clk = ~clk;

  spi_bus_slave dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_spi_cs_n(cs_n),
    .i_spi_sck (sck),
    .i_spi_mosi(mosi),
    .o_spi_miso(miso),
    .o_wr_n    (wr_n),
    .o_rd_n    (rd_n),
    .o_addr    (addr),
    .o_data    (data),
    .i_data    (rdata)
  );

  // Strobe monitor: logs each pulse's bus values and counts low cycles.
  logic       wr_prev = 1'b1;
  logic       rd_prev = 1'b1;
  int         wr_low = 0;
  int         both_low = 0;
  logic [6:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [6:0] rd_addr_q[$];

  always @(negedge clk) begin
    if (!wr_n) wr_low <= wr_low + 1;
    if (!wr_n && !rd_n) both_low <= both_low + 1;
    if (!wr_n && wr_prev) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(data);
    end
    if (!rd_n && rd_prev) rd_addr_q.push_back(addr);
    wr_prev <= wr_n;
    rd_prev <= rd_n;
  end

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    r = miso;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic write_frame(input logic [7:0] cmd, input logic [7:0] d, output logic [7:0] rx_d);
    logic [7:0] rx_c;
    cs_begin();
    spi_byte(cmd, rx_c);
    spi_byte(d, rx_d);
    cs_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_n !== 1'b1) begin bad++; $display("FAIL reset_wr_n got=%b exp=1", wr_n); end
    total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL reset_rd_n got=%b exp=1", rd_n); end
    total++; if (addr !== 7'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", addr); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_write();
    int wb, lb, rb;
    logic [7:0] rx;
    wb = wr_addr_q.size(); lb = wr_low; rb = rd_addr_q.size();
    write_frame(8'h01, 8'hA5, rx);
    total++;
    if (wr_addr_q.size() - wb !== 1) begin
      bad++; $display("FAIL write_pulses got=%0d exp=1", wr_addr_q.size() - wb);
    end
    total++;
    if (wr_low - lb !== 1) begin bad++; $display("FAIL write_width got=%0d exp=1", wr_low - lb); end
    if (wr_addr_q.size() > wb) begin
      total++;
      if (wr_addr_q[wb] !== 7'h01) begin
        bad++; $display("FAIL write_addr got=%h exp=01", wr_addr_q[wb]);
      end
      total++;
      if (wr_data_q[wb] !== 8'hA5) begin
        bad++; $display("FAIL write_data got=%h exp=a5", wr_data_q[wb]);
      end
    end
    total++;
    if (rd_addr_q.size() !== rb) begin bad++; $display("FAIL write_no_rd got=%0d", rd_addr_q.size() - rb); end
    total++; if (rx !== 8'h00) begin bad++; $display("FAIL write_miso got=%h exp=00", rx); end
  endtask

  task automatic test_read();
    int rb, wb;
    logic [7:0] rx_c, rx_d;
    rdata = 8'h3C;
    rb = rd_addr_q.size(); wb = wr_addr_q.size();
    cs_begin();
    spi_byte(8'h81, rx_c);
    total++;
    if (rd_addr_q.size() - rb !== 1) begin
      bad++; $display("FAIL read_pulses got=%0d exp=1", rd_addr_q.size() - rb);
    end
    if (rd_addr_q.size() > rb) begin
      total++;
      if (rd_addr_q[rb] !== 7'h01) begin bad++; $display("FAIL read_addr got=%h exp=01", rd_addr_q[rb]); end
    end
    spi_byte(8'h00, rx_d);
    cs_end();
    total++; if (rx_c !== 8'h00) begin bad++; $display("FAIL read_cmd_miso got=%h exp=00", rx_c); end
    total++; if (rx_d !== 8'h3C) begin bad++; $display("FAIL read_miso got=%h exp=3c", rx_d); end
    total++;
    if (wr_addr_q.size() !== wb) begin bad++; $display("FAIL read_no_wr got=%0d", wr_addr_q.size() - wb); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL read_idle_miso got=%b exp=0", miso); end
    rdata = 8'h00;
  endtask

  task automatic test_burst();
    int wb;
    logic [7:0] rx;
    logic [6:0] exp2;
`ifdef SPI_AUTOINC_EN
    exp2 = 7'h00;
`else
    exp2 = 7'h7F;
`endif
    wb = wr_addr_q.size();
    cs_begin();
    spi_byte(8'h7F, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    cs_end();
    total++;
    if (wr_addr_q.size() - wb !== 2) begin
      bad++; $display("FAIL burst_pulses got=%0d exp=2", wr_addr_q.size() - wb);
    end
    if (wr_addr_q.size() - wb >= 2) begin
      total++;
      if (wr_addr_q[wb] !== 7'h7F) begin bad++; $display("FAIL burst_addr0 got=%h exp=7f", wr_addr_q[wb]); end
      total++;
      if (wr_data_q[wb] !== 8'h11) begin bad++; $display("FAIL burst_data0 got=%h exp=11", wr_data_q[wb]); end
      total++;
      if (wr_addr_q[wb+1] !== exp2) begin
        bad++; $display("FAIL burst_addr1 got=%h exp=%h", wr_addr_q[wb+1], exp2);
      end
      total++;
      if (wr_data_q[wb+1] !== 8'h22) begin
        bad++; $display("FAIL burst_data1 got=%h exp=22", wr_data_q[wb+1]);
      end
    end
  endtask

  task automatic test_abort();
    int wb;
    logic [7:0] rx;
    logic r;
    wb = wr_addr_q.size();
    cs_begin();
    spi_byte(8'h00, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
    cs_end();
    total++;
    if (wr_addr_q.size() !== wb) begin bad++; $display("FAIL abort_no_wr got=%0d exp=0", wr_addr_q.size() - wb); end
    write_frame(8'h00, 8'h5A, rx);
    total++;
    if (wr_addr_q.size() - wb !== 1) begin
      bad++; $display("FAIL abort_next_pulses got=%0d exp=1", wr_addr_q.size() - wb);
    end
    total++; if (data !== 8'h5A) begin bad++; $display("FAIL abort_next_data got=%h exp=5a", data); end
    total++; if (addr !== 7'h00) begin bad++; $display("FAIL abort_next_addr got=%h exp=00", addr); end
  endtask

  task automatic test_cs_same_edge();
    int wb;
    logic [7:0] rx;
    logic r;
    wb = wr_addr_q.size();
    cs_begin();
    spi_byte(8'h02, rx);
    for (int i = 0; i < 7; i++) spi_bit(1'b1, r);
    mosi = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (wr_addr_q.size() !== wb) begin bad++; $display("FAIL same_edge_no_wr got=%0d exp=0", wr_addr_q.size() - wb); end
    total++; if (data !== 8'h5A) begin bad++; $display("FAIL same_edge_data got=%h exp=5a", data); end
  endtask

  task automatic test_reset_mid();
    int wb;
    logic [7:0] rx;
    logic r;
    write_frame(8'h45, 8'h99, rx);
    total++; if (data !== 8'h99) begin bad++; $display("FAIL pre_reset_data got=%h exp=99", data); end
    wb = wr_addr_q.size();
    cs_begin();
    spi_byte(8'h03, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_n !== 1'b1) begin bad++; $display("FAIL mid_reset_wr_n got=%b exp=1", wr_n); end
    total++; if (addr !== 7'h00) begin bad++; $display("FAIL mid_reset_addr got=%h exp=00", addr); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL mid_reset_data got=%h exp=00", data); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL mid_reset_miso got=%b exp=0", miso); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
    spi_byte(8'h66, rx);
    cs_end();
    total++;
    if (wr_addr_q.size() !== wb) begin bad++; $display("FAIL mid_reset_no_wr got=%0d exp=0", wr_addr_q.size() - wb); end
    write_frame(8'h03, 8'h77, rx);
    total++;
    if (wr_addr_q.size() - wb !== 1) begin
      bad++; $display("FAIL post_reset_pulses got=%0d exp=1", wr_addr_q.size() - wb);
    end
    total++; if (addr !== 7'h03) begin bad++; $display("FAIL post_reset_addr got=%h exp=03", addr); end
    total++; if (data !== 8'h77) begin bad++; $display("FAIL post_reset_data got=%h exp=77", data); end
  endtask

  task automatic test_exclusive();
    total++;
    if (both_low !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", both_low); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst();
    test_abort();
    test_cs_same_edge();
    test_reset_mid();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_bus_slave.md
SPI_BUS_SLAVE -- requirements
Module: spi_bus_slave

Interface
REQ-001 The block SHALL have one clock, `i_clk` (50 MHz system clock); reset is asynchronous and active-low, `i_rst_n`.
REQ-002 The ports SHALL be, clock and reset first:
- `i_clk` input 1: system clock.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_spi_cs_n` input 1: SPI chip select, active-low, asynchronous to `i_clk`.
- `i_spi_sck` input 1: SPI clock, mode 0, asynchronous to `i_clk`.
- `i_spi_mosi` input 1: SPI data from host.
- `o_spi_miso` output 1: SPI data to host.
- `o_wr_n` output 1: register-bus write strobe, active-low.
- `o_rd_n` output 1: register-bus read strobe, active-low.
- `o_addr` output 7: register-bus address.
- `o_data` output 8: register-bus write data.
- `i_data` input 8: register-bus read data, combinational from the addressed register.

Function
REQ-003 `i_spi_cs_n`, `i_spi_sck` and `i_spi_mosi` SHALL each pass through a 2-flop synchronizer; SCK rise/fall SHALL be detected on the synchronized copies.
REQ-004 The supported SCK rate SHALL be i_clk/8 maximum (SCK high and low each ≥4 i_clk cycles); faster SCK is undefined.
REQ-005 The frame format SHALL be: command byte, then one or more data bytes, all MSB first, sampled on SCK rise.
REQ-006 Command byte: bit7=1 is a read, bit7=0 is a write; bits 6:0 are the start address.
REQ-007 The FSM SHALL have three states:
- IDLE: CS high.
- CMD: CS low, receiving the command byte.
- DATA: receiving or transmitting data bytes.
REQ-008 FSM transitions:
- IDLE→CMD on synchronized CS fall.
- CMD→DATA on the 8th SCK rise.
- Any state→IDLE on synchronized CS rise.
REQ-009 A 3-bit bit counter SHALL clear on CS fall and wrap 7→0 at each byte boundary.
REQ-010 Write: one i_clk cycle after the detected 8th rise of a data byte, `o_wr_n` SHALL be low for exactly one cycle with `o_addr`/`o_data` valid; `o_addr`/`o_data` SHALL hold until the next strobe.
REQ-011 Read: one cycle after the 8th rise of the command byte (and after each following data byte), `o_rd_n` SHALL be low for one cycle; `i_data` SHALL be captured into the MISO shift register on that same cycle.
REQ-012 `o_spi_miso` SHALL present the captured bit7 on the next detected SCK fall and shift MSB first on subsequent falls.
REQ-013 `o_spi_miso` SHALL be 0 in IDLE and during CMD; write frames SHALL drive 0.
REQ-014 CS rise mid-byte SHALL discard the partial byte, issue no strobe and return to IDLE next cycle.
REQ-015 A CS rise in the same cycle as an 8th-bit rise SHALL abort; the CS rise has priority and no strobe is issued.
REQ-016 `o_wr_n` and `o_rd_n` SHALL never be low in the same cycle.
REQ-017 Strobes SHALL be spaced ≥8 SCK periods apart by construction; no back-pressure exists.

Reset
REQ-018 While `i_rst_n`=0, the block SHALL force:
- FSM to IDLE, bit counter 0, shift registers 0.
- `o_wr_n`=1, `o_rd_n`=1.
- `o_addr`=7'h00, `o_data`=8'h00, `o_spi_miso`=0.
REQ-019 Reset asserted mid-frame SHALL abort without a strobe; after release the block SHALL wait for a fresh CS fall, ignoring the remainder of the frame in progress.

Configuration
REQ-020 With macro `SPI_AUTOINC_EN` defined, each data byte after the first in a frame SHALL target `o_addr`+1, wrapping 7'h7F→7'h00.
REQ-021 Without `SPI_AUTOINC_EN`, all data bytes in a frame SHALL target the command address unchanged.

Verification
REQ-022 Reset values: assert `i_rst_n`=0 → all outputs equal REQ-018 values.
REQ-023 Write 0x01, 0xA5 (SCK i_clk/8) → single `o_wr_n` pulse, 1 cycle wide, with `o_addr`=7'h01, `o_data`=8'hA5.
REQ-024 Read 0x81 with `i_data`=8'h3C → one `o_rd_n` pulse with `o_addr`=7'h01; MISO returns 0x3C on the data byte.
REQ-025 Burst write 0x7F, 0x11, 0x22:
- With `SPI_AUTOINC_EN`: strobes at addr 7'h7F then 7'h00.
- Without: both strobes at 7'h7F.
REQ-026 Write 0x00 then CS rise after 5 data bits → no `o_wr_n` pulse; a following full frame 0x00, 0x5A writes 8'h5A.
REQ-027 `i_rst_n` pulsed low mid data byte → no strobe, outputs at reset values; the next complete frame writes correctly.
